// File: rtl/ps2_pkg.sv
// Shared types, timing defaults and helpers for the PS/2 host transmitter.
// Holds the FSM state encoding, the default timing parameters with their
// derived cycle counts, and the odd-parity helper used when building a frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        BITS,
        STOP,
        ACK,
        WAITIDLE,
        FAIL
    } state_t;

    localparam int unsigned DEF_CLK_MHZ              = 50;
    localparam int unsigned DEF_INHIBIT_US           = 100;
    localparam int unsigned DEF_FIRST_CLK_TIMEOUT_MS = 15;
    localparam int unsigned DEF_FRAME_TIMEOUT_MS     = 2;
    localparam int unsigned DEF_FILTER_CYC           = 8;
    localparam int unsigned DEF_MAX_RETRY            = 2;

    function automatic int unsigned us_to_cycles(input int unsigned mhz, input int unsigned us);
        return mhz * us;
    endfunction

    function automatic int unsigned ms_to_cycles(input int unsigned mhz, input int unsigned ms);
        return mhz * ms * 1000;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned DEF_INHIBIT_CNT   = us_to_cycles(DEF_CLK_MHZ, DEF_INHIBIT_US);
    localparam int unsigned DEF_FIRST_CLK_CNT = ms_to_cycles(DEF_CLK_MHZ, DEF_FIRST_CLK_TIMEOUT_MS);
    localparam int unsigned DEF_FRAME_CNT     = ms_to_cycles(DEF_CLK_MHZ, DEF_FRAME_TIMEOUT_MS);

    // Odd parity: the 9-bit {parity, data} word always has an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-flop synchronizer followed by a stability
// filter. The filtered level only changes after FILTER_CYC consecutive equal
// synchronized samples; fall pulses for one cycle on a filtered 1->0 change.
// Ports: clk, reset (async, active-high), raw (async pin level),
//        sync (synchronized level), filt (filtered level), fall (edge pulse).
module ps2_line_filter #(
    parameter int unsigned FILTER_CYC = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync,
    output logic filt,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_CYC) + 1;

    logic          meta;
    logic [CW-1:0] cnt;

    // Idle bus is high, so everything resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            filt <= 1'b1;
            fall <= 1'b0;
            cnt  <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            fall <= 1'b0;
            if (sync == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYC - 1)) begin
                filt <= sync;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device falling edges, then check the device ACK.
// Ports: clk, reset (async, active-high); tx_data/tx_valid/tx_ready accept a
//        command byte; tx_done / tx_error one-cycle result pulses; busy high
//        outside IDLE; ps2_clk_i/ps2_data_i raw pins; ps2_clk_oe/ps2_data_oe
//        pull the open-collector lines low when 1.
// Build option: define PS2_TX_RETRY_EN to retry a failed frame up to
// MAX_RETRY times before reporting tx_error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_MHZ              = DEF_CLK_MHZ,
    parameter int unsigned INHIBIT_US           = DEF_INHIBIT_US,
    parameter int unsigned FIRST_CLK_TIMEOUT_MS = DEF_FIRST_CLK_TIMEOUT_MS,
    parameter int unsigned FRAME_TIMEOUT_MS     = DEF_FRAME_TIMEOUT_MS,
    parameter int unsigned FILTER_CYC           = DEF_FILTER_CYC,
    parameter int unsigned MAX_RETRY            = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INHIBIT_CNT = us_to_cycles(CLK_MHZ, INHIBIT_US);
    localparam int unsigned FIRST_CNT   = ms_to_cycles(CLK_MHZ, FIRST_CLK_TIMEOUT_MS);
    localparam int unsigned FRAME_CNT   = ms_to_cycles(CLK_MHZ, FRAME_TIMEOUT_MS);
    localparam int unsigned TMR_MAX     = max3(INHIBIT_CNT, FIRST_CNT, FRAME_CNT);
    localparam int unsigned TW          = $clog2(TMR_MAX) + 1;

    state_t          state, state_next;
    logic [TW-1:0]   tmr, tmr_next;
    logic [3:0]      bit_cnt, bit_cnt_next;
    logic [8:0]      shift, shift_next;
    logic            clk_oe_next, data_oe_next, done_next, error_next;
    logic            fail_now, frame_to;
    logic            clk_filt, clk_fall, data_filt, data_sync;
    logic            clk_sync_unused, data_fall_unused;

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
    logic [RW-1:0]   retry_cnt, retry_next;
    logic [7:0]      byte_q, byte_next;
`else
    localparam int unsigned MAX_RETRY_unused = MAX_RETRY;
`endif

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_i),
        .sync  (clk_sync_unused),
        .filt  (clk_filt),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_i),
        .sync  (data_sync),
        .filt  (data_filt),
        .fall  (data_fall_unused)
    );

    // State register plus all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= '0;
            byte_q      <= '0;
`endif
        end else begin
            state       <= state_next;
            tmr         <= tmr_next;
            bit_cnt     <= bit_cnt_next;
            shift       <= shift_next;
            ps2_clk_oe  <= clk_oe_next;
            ps2_data_oe <= data_oe_next;
            tx_done     <= done_next;
            tx_error    <= error_next;
            tx_ready    <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= retry_next;
            byte_q      <= byte_next;
`endif
        end
    end

    // Next-state and output logic; the single timer is cleared on entry to
    // INHIBIT, RTS and BITS and saturates otherwise.
    always_comb begin
        state_next   = state;
        tmr_next     = (tmr == TW'(TMR_MAX)) ? tmr : tmr + TW'(1);
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        clk_oe_next  = ps2_clk_oe;
        data_oe_next = ps2_data_oe;
        done_next    = 1'b0;
        error_next   = 1'b0;
        fail_now     = 1'b0;
        frame_to     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_next   = retry_cnt;
        byte_next    = byte_q;
`endif

        case (state)
            IDLE: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                tmr_next     = '0;
                if (tx_valid) begin
                    shift_next   = {odd_parity(tx_data), tx_data};
                    bit_cnt_next = '0;
                    clk_oe_next  = 1'b1;
                    state_next   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    byte_next    = tx_data;
                    retry_next   = '0;
`endif
                end
            end
            INHIBIT: begin
                // data_oe registers one cycle early so it is low on the last inhibit cycle
                if (tmr == TW'(INHIBIT_CNT - 1)) begin
                    state_next   = RTS;
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b1;
                    tmr_next     = '0;
                end else if (tmr + TW'(2) >= TW'(INHIBIT_CNT)) begin
                    data_oe_next = 1'b1;
                end
            end
            RTS: begin
                if (clk_fall) begin
                    state_next = BITS;
                    tmr_next   = '0;
                end else if (tmr == TW'(FIRST_CNT - 1)) begin
                    fail_now = 1'b1;
                end
            end
            BITS: begin
                frame_to = 1'b1;
                if (clk_fall) begin
                    data_oe_next = ~shift[0];
                    shift_next   = {1'b0, shift[8:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) state_next = STOP;
                end
            end
            STOP: begin
                frame_to = 1'b1;
                if (clk_fall) begin
                    data_oe_next = 1'b0;
                    state_next   = ACK;
                end
            end
            ACK: begin
                frame_to = 1'b1;
                if (clk_fall) begin
                    if (!data_filt) state_next = WAITIDLE;
                    else            fail_now   = 1'b1;
                end
            end
            WAITIDLE: begin
                frame_to = 1'b1;
                if (clk_filt && data_sync) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            FAIL: begin
                state_next = IDLE;
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt != RW'(MAX_RETRY)) begin
                    state_next   = INHIBIT;
                    clk_oe_next  = 1'b1;
                    shift_next   = {odd_parity(byte_q), byte_q};
                    bit_cnt_next = '0;
                    tmr_next     = '0;
                    retry_next   = retry_cnt + RW'(1);
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        // Frame timeout; a completing frame wins over a same-cycle expiry.
        if (frame_to && (tmr == TW'(FRAME_CNT - 1)) && !done_next) fail_now = 1'b1;

        if (fail_now) begin
            state_next   = FAIL;
            clk_oe_next  = 1'b0;
            data_oe_next = 1'b0;
`ifdef PS2_TX_RETRY_EN
            error_next   = (retry_cnt == RW'(MAX_RETRY));
`else
            error_next   = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Timing is scaled down (1 MHz clock parameter) so every phase fits a short run.
module tb_ps2_host_tx;

    localparam int unsigned CLK_MHZ   = 1;
    localparam int unsigned INH_US    = 100;
    localparam int unsigned FIRST_MS  = 15;
    localparam int unsigned FRAME_MS  = 2;
    localparam int unsigned FILTER    = 8;
    localparam int unsigned RETRIES   = 2;
    localparam int          INH_CNT   = CLK_MHZ * INH_US;
    localparam int          FIRST_CNT = CLK_MHZ * 1000 * FIRST_MS;
    localparam int          HALF      = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;

    // Open-collector wires: low if either side pulls.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_MHZ(CLK_MHZ), .INHIBIT_US(INH_US), .FIRST_CLK_TIMEOUT_MS(FIRST_MS),
        .FRAME_TIMEOUT_MS(FRAME_MS), .FILTER_CYC(FILTER), .MAX_RETRY(RETRIES)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, rb_bad = 0;
    int inh_n = 0, inh_last = 0, inh_run = 0;
    logic exp_q[$];

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    // Measures every clock-inhibit phase and watches ready/busy complementarity.
    always @(negedge clk) begin
        if (tx_ready === busy) rb_bad <= rb_bad + 1;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            inh_last <= inh_run;
            inh_n    <= inh_n + 1;
            inh_run  <= 0;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard entry for one frame as the device sees it on its rising edges.
    task automatic push_frame(input logic [7:0] d, input logic par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
    endtask

    task automatic request(input logic [7:0] d);
        @(negedge clk);
        check("ready_before_req", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_latency_clk_oe", ps2_clk_oe, 1);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_rts(input int prev);
        int k;
        k = 0;
        while (inh_n == prev && k < INH_CNT + 300) begin
            @(negedge clk);
            k++;
        end
        check("rts_reached", inh_n != prev, 1);
        check("inhibit_len", inh_last, INH_CNT);
        check("rts_start_bit_low", ps2_data_oe, 1);
    endtask

    // Device generates 12 clocks, samples on each rising edge, ACKs or NAKs.
    task automatic dev_frame(input bit ack);
        logic e;
        for (int i = 0; i < 12; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 11) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bit", ps2_data_i, e);
                end
            end
            dev_clk = 1'b1;
            if (i == 10) dev_data = ~ack;
        end
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input int d0, input int e0);
        int k;
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("result_seen", (done_cnt != d0) || (err_cnt != e0), 1);
    endtask

    task automatic do_frame(input logic [7:0] d, input logic par, input bit ack, input bit exp_done);
        int d0, e0, p0;
        d0 = done_cnt;
        e0 = err_cnt;
        p0 = inh_n;
        push_frame(d, par);
        request(d);
        wait_rts(p0);
        dev_frame(ack);
        wait_result(d0, e0);
        check("done_pulses", done_cnt - d0, exp_done ? 1 : 0);
        check("error_pulses", err_cnt - e0, exp_done ? 0 : 1);
        repeat (3) @(negedge clk);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        check("ready_after", tx_ready, 1);
        check("busy_after", busy, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        bit         exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0, e0, p0, k;
        logic par;

        vecs[0] = '{data: 8'hED, ack: 1'b1, exp_par: 1'b1, exp_done: 1'b1};
        vecs[1] = '{data: 8'hF4, ack: 1'b1, exp_par: 1'b0, exp_done: 1'b1};
        vecs[2] = '{data: 8'h00, ack: 1'b1, exp_par: 1'b1, exp_done: 1'b1};
        vecs[3] = '{data: 8'h01, ack: 1'b1, exp_par: 1'b0, exp_done: 1'b1};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_error", tx_error, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 4; v++)
            do_frame(vecs[v].data, vecs[v].exp_par, vecs[v].ack, vecs[v].exp_done);

`ifndef PS2_TX_RETRY_EN
        // Device holds data high at the ACK edge.
        par = ($countones(8'h3C) % 2 == 0);
        do_frame(8'h3C, par, 1'b0, 1'b0);

        // Device never clocks: error after the first-clock timeout.
        d0 = done_cnt;
        p0 = inh_n;
        request(8'h55);
        wait_rts(p0);
        k = 1;
        while (!tx_error && k < FIRST_CNT + 100) begin
            @(negedge clk);
            k++;
        end
        check("first_clk_timeout_cycles", k, FIRST_CNT);
        check("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        check("timeout_no_done", done_cnt - d0, 0);
        repeat (3) @(negedge clk);
`else
        // Device NAKs twice then ACKs: three inhibit phases, one tx_done.
        d0 = done_cnt;
        e0 = err_cnt;
        p0 = inh_n;
        k  = inh_n;
        par = ($countones(8'h99) % 2 == 0);
        request(8'h99);
        for (int a = 0; a < 3; a++) begin
            check("retry_busy_held", busy, 1);
            wait_rts(p0);
            p0 = inh_n;
            push_frame(8'h99, par);
            dev_frame(a == 2);
        end
        wait_result(d0, e0);
        repeat (200) @(negedge clk);
        check("retry_done_pulses", done_cnt - d0, 1);
        check("retry_error_pulses", err_cnt - e0, 0);
        check("retry_inhibit_phases", inh_n - k, 3);
        check("retry_ready_after", tx_ready, 1);
`endif

        // Reset in BITS of 0xFF while the start bit is still driven.
        p0 = inh_n;
        request(8'hFF);
        wait_rts(p0);
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check("bits_start_driven", ps2_data_oe, 1);
        check("bits_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_ready", tx_ready, 1);
        exp_q.delete();
        do_frame(8'hFF, 1'b1, 1'b1, 1'b1);

        check("done_error_exclusive", both_cnt, 0);
        check("ready_busy_complement", rb_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
